// File: rtl/fsquare_seq.sv
// rtl/fsquare_seq.sv - iterative single-precision squarer, truncating, flush-to-zero
module fsquare_seq #(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] s
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              exp_r;
    logic [MANT_W-1:0]       m_r;
    logic [2*MANT_W-1:0]     p_r;
    logic [4:0]              cnt_r;

    logic                    special;
    logic [2*MANT_W-1:0]     addend;
    logic [9:0]              e_base;
    logic [9:0]              e_fin;
    logic [22:0]             frac;
    logic [31:0]             s_calc;

    // Zero/denormal and inf/NaN operands skip the multiplier entirely
    assign special = (a[30:23] == 8'h00) || (a[30:23] == 8'hFF);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign addend  = {{MANT_W{1'b0}}, m_r} << cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = special ? NORM : MUL;
            MUL:  if (cnt_r == 5'(MANT_W - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Product of two [1,2) significands lies in [1,4); bit 47 picks the binade
    always_comb begin
        e_base = {1'b0, exp_r, 1'b0} - 10'(EXP_BIAS);
        e_fin  = e_base + {9'd0, p_r[2*MANT_W-1]};
        frac   = p_r[2*MANT_W-1] ? p_r[2*MANT_W-2 -: 23] : p_r[2*MANT_W-3 -: 23];
        s_calc = 32'h0000_0000;
        if (exp_r == 8'h00) begin
            s_calc = 32'h0000_0000;
        end else if (exp_r == 8'hFF) begin
            s_calc = (m_r[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        end else if ($signed(e_fin) >= 10'sd255) begin
            s_calc = 32'h7F80_0000;
        end else if ($signed(e_fin) <= 10'sd0) begin
            s_calc = 32'h0000_0000;
        end else begin
            s_calc = {1'b0, e_fin[7:0], frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_r <= 8'd0;
            m_r   <= '0;
            p_r   <= '0;
            cnt_r <= 5'd0;
            s     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_r <= a[30:23];
                        m_r   <= {1'b1, a[22:0]};
                        p_r   <= '0;
                        cnt_r <= 5'd0;
                    end
                end
                MUL: begin
                    if (m_r[cnt_r]) p_r <= p_r + addend;
                    cnt_r <= cnt_r + 5'd1;
                end
                NORM: s <= s_calc;
                default: ;
            endcase
        end
    end

endmodule
